fifo_ref_checker: RTL and testbench

Synthesizable cycle-accurate reference model and checker for the synchronous FIFO. It sits directly downstream of the FIFO DUT on the same interface signals the bench monitor samples. It consumes the DUT inputs and outputs every cycle, predicts the expected outputs, and flags per-signal mismatches with pass/fail counters. It lets emulation and formal runs check the FIFO without the class-based scoreboard.

---
 rtl/fifo_ref_checker_if.sv | 33 +++
 rtl/fifo_ref_checker.sv | 130 +++++++++++++
 tb/tb_fifo_ref_checker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ref_checker_if.sv
// Purpose : bundle of every signal exchanged between the FIFO DUT and its environment.
// Latency : none, wires only.
// Backpressure: none; the FIFO flags carry flow control, and this bundle just carries them.
// Ports   : data_in/wr_en/rd_en (DUT inputs), data_out/wr_ack/overflow/underflow/
//           full/almostfull/empty/almostempty (DUT outputs).
//           master = side that drives the bus (bench/DUT), slave = passive observer.
interface fifo_ref_checker_if #(
    parameter int FIFO_WIDTH = 16
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  almostfull;
    logic                  empty;
    logic                  almostempty;

    modport master (
        output data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, almostfull, empty, almostempty
    );

    modport slave (
        input data_in, wr_en, rd_en,
        input data_out, wr_ack, overflow, underflow,
        input full, almostfull, empty, almostempty
    );
endinterface

// File: rtl/fifo_ref_checker.sv
// Purpose : cycle-accurate reference model of the synchronous FIFO plus a per-signal output checker.
// Latency : exp_* match DUT timing (registered, 1 edge); mismatch/counters appear 1 edge after the checked cycle.
// Backpressure: none; it only observes the bus and can never stall it.
// Ports   : clk, rst (sync, active-high); mon (slave view of the DUT bus);
//           exp_* predicted DUT outputs; mismatch_vec/mismatch/sticky_error and
//           correct_count/error_count report the comparison results.
module fifo_ref_checker #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_ref_checker_if.slave     mon,
    output logic [FIFO_WIDTH-1:0] exp_data_out,
    output logic                  exp_wr_ack,
    output logic                  exp_overflow,
    output logic                  exp_underflow,
    output logic                  exp_full,
    output logic                  exp_almostfull,
    output logic                  exp_empty,
    output logic                  exp_almostempty,
    output logic [7:0]            mismatch_vec,
    output logic                  mismatch,
    output logic                  sticky_error,
    output logic [31:0]           correct_count,
    output logic [31:0]           error_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  armed;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [7:0]            cmp_vec;

    // Full/empty gating alone resolves simultaneous requests: at empty only the
    // write lands, at full only the read lands, otherwise both do.
    always_comb begin
        wr_ok = mon.wr_en && (count != DEPTH_C);
        rd_ok = mon.rd_en && (count != '0);
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= mon.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            exp_data_out  <= '0;
            exp_wr_ack    <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                exp_data_out <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            exp_wr_ack    <= wr_ok;
            exp_overflow  <= mon.wr_en && !wr_ok;
            exp_underflow <= mon.rd_en && !rd_ok;
        end
    end

    always_comb begin
        exp_full        = (count == DEPTH_C);
        exp_almostfull  = (count == DEPTH_C - CNT_W'(1));
        exp_empty       = (count == '0);
        exp_almostempty = (count == CNT_W'(1));
    end

    always_comb begin
        cmp_vec    = '0;
        cmp_vec[0] = (mon.data_out    != exp_data_out);
        cmp_vec[1] = (mon.wr_ack      != exp_wr_ack);
        cmp_vec[2] = (mon.overflow    != exp_overflow);
        cmp_vec[3] = (mon.underflow   != exp_underflow);
        cmp_vec[4] = (mon.full        != exp_full);
        cmp_vec[5] = (mon.almostfull  != exp_almostfull);
        cmp_vec[6] = (mon.empty       != exp_empty);
        cmp_vec[7] = (mon.almostempty != exp_almostempty);
    end

    // The first edge out of reset only arms the checker: DUT outputs in the
    // cycle straddling reset release are not yet meaningful to compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed         <= 1'b0;
            mismatch_vec  <= '0;
            sticky_error  <= 1'b0;
            correct_count <= '0;
            error_count   <= '0;
        end else begin
            armed <= 1'b1;
            if (armed) begin
                mismatch_vec <= cmp_vec;
                if (|cmp_vec) begin
                    sticky_error <= 1'b1;
                    if (error_count != 32'hFFFF_FFFF) begin
                        error_count <= error_count + 32'd1;
                    end
                end else if (correct_count != 32'hFFFF_FFFF) begin
                    correct_count <= correct_count + 32'd1;
                end
            end
        end
    end

    assign mismatch = |mismatch_vec;

endmodule

// File: tb/tb_fifo_ref_checker.sv
module tb_fifo_ref_checker;
    logic        clk;
    logic        rst;
    logic [15:0] exp_data_out;
    logic        exp_wr_ack, exp_overflow, exp_underflow;
    logic        exp_full, exp_almostfull, exp_empty, exp_almostempty;
    logic [7:0]  mismatch_vec;
    logic        mismatch, sticky_error;
    logic [31:0] correct_count, error_count;

    int vectors;
    int miscompares;

    fifo_ref_checker_if #(.FIFO_WIDTH(16)) bus ();

    fifo_ref_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .mon             (bus.slave),
        .exp_data_out    (exp_data_out),
        .exp_wr_ack      (exp_wr_ack),
        .exp_overflow    (exp_overflow),
        .exp_underflow   (exp_underflow),
        .exp_full        (exp_full),
        .exp_almostfull  (exp_almostfull),
        .exp_empty       (exp_empty),
        .exp_almostempty (exp_almostempty),
        .mismatch_vec    (mismatch_vec),
        .mismatch        (mismatch),
        .sticky_error    (sticky_error),
        .correct_count   (correct_count),
        .error_count     (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for a correct FIFO DUT driving the observed bus (stimulus only).
    logic [15:0] q[$];
    int          dcount;
    logic [15:0] d_out;
    logic        d_ack, d_ovf, d_unf;
    logic        force_full_low;
    bit          w_ok, r_ok;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            dcount <= 0;
            d_out  <= '0;
            d_ack  <= 1'b0;
            d_ovf  <= 1'b0;
            d_unf  <= 1'b0;
        end else begin
            w_ok = bus.wr_en && (q.size() < 8);
            r_ok = bus.rd_en && (q.size() > 0);
            if (r_ok) d_out <= q.pop_front();
            if (w_ok) q.push_back(bus.data_in);
            d_ack  <= w_ok;
            d_ovf  <= bus.wr_en && !w_ok;
            d_unf  <= bus.rd_en && !r_ok;
            dcount <= q.size();
        end
    end

    assign bus.data_out    = d_out;
    assign bus.wr_ack      = d_ack;
    assign bus.overflow    = d_ovf;
    assign bus.underflow   = d_unf;
    assign bus.full        = (dcount == 8) && !force_full_low;
    assign bus.almostfull  = (dcount == 7);
    assign bus.empty       = (dcount == 0);
    assign bus.almostempty = (dcount == 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs; return #1 after the edge so outputs are settled.
    task automatic step(input logic w, input logic r, input logic [15:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, exp_full, exp_almostfull, exp_empty, exp_almostempty};
    endfunction

    function automatic logic [31:0] stat();
        return {29'd0, exp_wr_ack, exp_overflow, exp_underflow};
    endfunction

    initial begin
        vectors        = 0;
        miscompares    = 0;
        force_full_low = 1'b0;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        bus.data_in    = '0;

        // Reset state
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        check("rst_data", 32'(exp_data_out), 32'h0);
        check("rst_stat", stat(), 32'h0);
        check("rst_flags", flags(), 32'h2);
        check("rst_mvec", 32'(mismatch_vec), 32'h0);
        check("rst_mismatch", 32'(mismatch), 32'h0);
        check("rst_sticky", 32'(sticky_error), 32'h0);
        check("rst_correct", correct_count, 32'h0);
        check("rst_error", error_count, 32'h0);
        rst = 1'b0;

        // Fill with 1111..8888
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 16'(i * 16'h1111));
            if (i == 7) check("fill7_flags", flags(), 32'h4);
        end
        check("fill8_flags", flags(), 32'h8);
        check("fill8_ack", stat(), 32'h4);
        check("fill8_correct", correct_count, 32'd7);
        check("fill8_error", error_count, 32'd0);

        // Overflow write
        step(1, 0, 16'h9999);
        check("ovf_stat", stat(), 32'h2);
        check("ovf_flags", flags(), 32'h8);
        check("ovf_correct", correct_count, 32'd8);

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 16'h0);
            check("drain_data", 32'(exp_data_out), 32'(16'(i * 16'h1111)));
            if (i == 1) check("drain1_flags", flags(), 32'h4);
        end
        check("drain_flags", flags(), 32'h2);
        check("drain_correct", correct_count, 32'd16);

        // Underflow read
        step(0, 1, 16'h0);
        check("unf_stat", stat(), 32'h1);
        check("unf_flags", flags(), 32'h2);
        check("unf_hold", 32'(exp_data_out), 32'h8888);

        // Simultaneous at empty: write only
        step(1, 1, 16'h5A5A);
        check("sim0_stat", stat(), 32'h5);
        check("sim0_flags", flags(), 32'h1);
        check("sim0_hold", 32'(exp_data_out), 32'h8888);

        for (int i = 1; i <= 7; i++) step(1, 0, 16'(16'h2000 + i));
        check("refill_flags", flags(), 32'h8);

        // Simultaneous at full: read only
        step(1, 1, 16'hDEAD);
        check("sim8_data", 32'(exp_data_out), 32'h5A5A);
        check("sim8_stat", stat(), 32'h2);
        check("sim8_flags", flags(), 32'h4);

        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 16'h0);
            check("to3_data", 32'(exp_data_out), 32'(16'h2000 + i));
        end

        // Simultaneous at count 3
        step(1, 1, 16'hABCD);
        check("sim3_data", 32'(exp_data_out), 32'h2005);
        check("sim3_stat", stat(), 32'h4);
        check("sim3_flags", flags(), 32'h0);
        step(0, 1, 16'h0);
        check("sim3_rd1", 32'(exp_data_out), 32'h2006);
        step(0, 1, 16'h0);
        check("sim3_rd2", 32'(exp_data_out), 32'h2007);
        step(0, 1, 16'h0);
        check("sim3_rd3", 32'(exp_data_out), 32'hABCD);
        check("sim3_empty", flags(), 32'h2);
        check("sim3_error", error_count, 32'd0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h3000 + i));
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 16'h0);
            check("wrap5_data", 32'(exp_data_out), 32'(16'h3000 + i));
        end
        for (int i = 0; i < 6; i++) step(1, 0, 16'(16'h4000 + i));
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 16'h0);
            check("wrap6_data", 32'(exp_data_out), 32'(16'h4000 + i));
        end
        check("wrap_error", error_count, 32'd0);
        check("wrap_correct", correct_count, 32'd56);

        // Fault injection: DUT full deasserted while full
        for (int i = 0; i < 8; i++) step(1, 0, 16'(16'h6000 + i));
        check("flt_flags", flags(), 32'h8);
        force_full_low = 1'b1;
        step(0, 0, 16'h0);
        force_full_low = 1'b0;
        check("flt_mvec", 32'(mismatch_vec), 32'h10);
        check("flt_mismatch", 32'(mismatch), 32'h1);
        check("flt_error", error_count, 32'd1);
        check("flt_sticky", 32'(sticky_error), 32'h1);
        check("flt_correct", correct_count, 32'd64);
        step(0, 0, 16'h0);
        check("post_mvec", 32'(mismatch_vec), 32'h0);
        check("post_mismatch", 32'(mismatch), 32'h0);
        check("post_sticky", 32'(sticky_error), 32'h1);
        check("post_error", error_count, 32'd1);
        check("post_correct", correct_count, 32'd65);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h0);
            check("to5_data", 32'(exp_data_out), 32'(16'h6000 + i));
        end
        check("to5_flags", flags(), 32'h0);

        // Mid-operation reset at count 5
        rst = 1'b1;
        step(0, 0, 16'h0);
        rst = 1'b0;
        check("mrst_data", 32'(exp_data_out), 32'h0);
        check("mrst_flags", flags(), 32'h2);
        check("mrst_correct", correct_count, 32'd0);
        check("mrst_error", error_count, 32'd0);
        check("mrst_sticky", 32'(sticky_error), 32'h0);
        step(1, 0, 16'h7777);
        check("arm_correct", correct_count, 32'd0);
        check("arm_flags", flags(), 32'h1);
        step(0, 1, 16'h0);
        check("resume_data", 32'(exp_data_out), 32'h7777);
        check("resume_flags", flags(), 32'h2);
        check("resume_correct", correct_count, 32'd1);
        step(0, 0, 16'h0);
        check("resume2_correct", correct_count, 32'd2);
        check("resume2_error", error_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
